// File: rtl/bus_pkg.sv
// Serial system bus configuration shared by the arbiter, master ports and slave ports.
package bus_pkg;

    localparam int unsigned BUS_MASTERS   = 2;
    localparam int unsigned BUS_SLAVE_LEN = 2;
    localparam int unsigned BUS_TIMEOUT   = 4096;

    // Index width that stays legal for a single-entry range.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned OWNER_W = idx_w(BUS_MASTERS);
    localparam int unsigned SLAVE_W = 2 ** BUS_SLAVE_LEN;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ADDR,
        ST_CONNECTED,
        ST_RELEASE
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection: first requester after the previous owner, wrapping.
module rr_picker
    import bus_pkg::*;
#(
    parameter  int unsigned N  = BUS_MASTERS,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          win_valid_c,
    output logic [IW-1:0] win_idx_c
);

    logic [IW-1:0] cand;

    // Scan last+1 .. last+N so the previous owner has the lowest priority.
    always_comb begin
        win_valid_c = 1'b0;
        win_idx_c   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(last_i) + k) % N);
            if (!win_valid_c && req_i[cand]) begin
                win_valid_c = 1'b1;
                win_idx_c   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: grants one master, captures its serial slave select,
// and holds the connection until done, request drop or timeout.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter  int unsigned NUM_MASTERS = BUS_MASTERS,
    parameter  int unsigned SLAVE_LEN   = BUS_SLAVE_LEN,
    parameter  int unsigned TIMEOUT     = BUS_TIMEOUT,
    localparam int unsigned OW          = idx_w(NUM_MASTERS),
    localparam int unsigned SW          = 2 ** SLAVE_LEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] sel_in,
    input  logic [NUM_MASTERS-1:0] done,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [NUM_MASTERS-1:0] busy,
    output logic [OW-1:0]          owner,
    output logic [SW-1:0]          slave_en,
    output logic                   timeout
);

    localparam int unsigned BW = idx_w(SLAVE_LEN);
    localparam int unsigned CW = idx_w(TIMEOUT);

    arb_state_e             state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] busy_q;
    logic [OW-1:0]          owner_q;
    logic [OW-1:0]          last_q;
    logic [SW-1:0]          slave_en_q;
    logic                   timeout_q;
    logic [BW-1:0]          bit_cnt_q;
    logic [SLAVE_LEN-1:0]   shreg_q;
    logic [SLAVE_LEN-1:0]   shreg_d;
    logic [CW-1:0]          cnt_q;

    logic          win_valid;
    logic [OW-1:0] win_idx;
    logic          own_req;
    logic          own_done;
    logic          own_sel;
    logic          last_bit;
    logic          cnt_expired;

    rr_picker #(
        .N (NUM_MASTERS)
    ) u_picker (
        .req_i       (req),
        .last_i      (last_q),
        .win_valid_c (win_valid),
        .win_idx_c   (win_idx)
    );

    assign own_req     = req[owner_q];
    assign own_done    = done[owner_q];
    assign own_sel     = sel_in[owner_q];
    assign last_bit    = (bit_cnt_q == BW'(SLAVE_LEN - 1));
    assign cnt_expired = (cnt_q == CW'(TIMEOUT - 1));

    // Select value including the bit being sampled this edge (LSB arrives first).
    always_comb begin
        shreg_d            = shreg_q;
        shreg_d[bit_cnt_q] = own_sel;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            busy_q     <= '0;
            owner_q    <= '0;
            last_q     <= OW'(NUM_MASTERS - 1);
            slave_en_q <= '0;
            timeout_q  <= 1'b0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            cnt_q      <= '0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (win_valid) begin
                        grant_q <= NUM_MASTERS'(1) << win_idx;
                        busy_q  <= ~(NUM_MASTERS'(1) << win_idx);
                        owner_q <= win_idx;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    bit_cnt_q <= '0;
                    state_q   <= own_req ? ST_ADDR : ST_RELEASE;
                end
                ST_ADDR: begin
                    if (!own_req) begin
                        state_q <= ST_RELEASE;
                    end else begin
                        shreg_q   <= shreg_d;
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                        if (last_bit) begin
                            slave_en_q <= SW'(1) << shreg_d;
                            state_q    <= ST_CONNECTED;
                        end
                    end
                end
                ST_CONNECTED: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    // done and request drop win over a coincident timeout.
                    if (own_done || !own_req) begin
                        state_q <= ST_RELEASE;
                    end else if (cnt_expired) begin
                        state_q   <= ST_RELEASE;
                        timeout_q <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    grant_q    <= '0;
                    busy_q     <= '0;
                    slave_en_q <= '0;
                    last_q     <= owner_q;
                    cnt_q      <= '0;
                    bit_cnt_q  <= '0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign busy     = busy_q;
    assign owner    = owner_q;
    assign slave_en = slave_en_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: a transaction-level timeline model
// queues expected output events, and a monitor pops them as the DUT produces them.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int unsigned NM  = BUS_MASTERS;
    localparam int unsigned SL  = BUS_SLAVE_LEN;
    localparam int unsigned TMO = 16;

    localparam int K_DONE = 0;
    localparam int K_DROP = 1;
    localparam int K_TMO  = 2;

    localparam int EV_GRANT = 0;
    localparam int EV_SLAVE = 1;
    localparam int EV_TMO   = 2;
    localparam int EV_REL   = 3;

    typedef struct {
        int                 kind;
        int                 cyc;
        logic [NM-1:0]      grant;
        logic [NM-1:0]      busy;
        logic [OWNER_W-1:0] owner;
        logic               chk_owner;
        logic [SLAVE_W-1:0] slave;
        logic               tmo;
    } ev_t;

    logic               clk    = 1'b0;
    logic               reset  = 1'b1;
    logic [NM-1:0]      req    = '0;
    logic [NM-1:0]      sel_in = '0;
    logic [NM-1:0]      done   = '0;
    logic [NM-1:0]      grant;
    logic [NM-1:0]      busy;
    logic [OWNER_W-1:0] owner;
    logic [SLAVE_W-1:0] slave_en;
    logic               timeout;

    ev_t exp_q[$];
    int  cyc        = 0;
    int  compared   = 0;
    int  mismatched = 0;
    int  model_last = int'(NM) - 1;
    logic [NM-1:0]      prev_grant = '0;
    logic [SLAVE_W-1:0] prev_slave = '0;

    bus_arbiter #(
        .NUM_MASTERS (NM),
        .SLAVE_LEN   (SL),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .sel_in   (sel_in),
        .done     (done),
        .grant    (grant),
        .busy     (busy),
        .owner    (owner),
        .slave_en (slave_en),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NM-1:0] oh_m(input int i);
        logic [NM-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [SLAVE_W-1:0] oh_s(input int i);
        logic [SLAVE_W-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic string ev_name(input int k);
        case (k)
            EV_GRANT: return "grant";
            EV_SLAVE: return "slave_en";
            EV_TMO:   return "timeout";
            default:  return "release";
        endcase
    endfunction

    // Priority order after a grant to master L is L+1, L+2, ... wrapping; L itself last.
    function automatic int rr_winner(input logic [NM-1:0] m);
        int idx;
        for (int k = 1; k <= int'(NM); k++) begin
            idx = (model_last + k) % int'(NM);
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int at, input int w, input int addr,
                           input logic has_slave);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.tmo  = (kind == EV_TMO);
        if (kind == EV_REL) begin
            e.grant     = '0;
            e.busy      = '0;
            e.owner     = '0;
            e.chk_owner = 1'b0;
            e.slave     = '0;
        end else begin
            e.grant     = oh_m(w);
            e.busy      = ~oh_m(w);
            e.owner     = OWNER_W'(w);
            e.chk_owner = 1'b1;
            e.slave     = has_slave ? oh_s(addr) : '0;
        end
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected %s event at cycle %0d: grant=%b busy=%b slave_en=%b timeout=%b",
                     ev_name(kind), cyc, grant, busy, slave_en, timeout);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc || grant !== e.grant || busy !== e.busy ||
            slave_en !== e.slave || timeout !== e.tmo || (e.chk_owner && owner !== e.owner)) begin
            mismatched++;
            $display("FAIL %s event: got %s@%0d grant=%b busy=%b owner=%0d slave_en=%b timeout=%b, expected %s@%0d grant=%b busy=%b owner=%0d slave_en=%b timeout=%b",
                     ev_name(e.kind), ev_name(kind), cyc, grant, busy, owner, slave_en, timeout,
                     ev_name(e.kind), e.cyc, e.grant, e.busy, e.owner, e.slave, e.tmo);
        end
    endtask

    // Monitor: turns output transitions into events and checks them against the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (grant !== prev_grant && grant != '0) check_ev(EV_GRANT);
            if (slave_en !== prev_slave && slave_en != '0) check_ev(EV_SLAVE);
            if (timeout === 1'b1) check_ev(EV_TMO);
            if (grant !== prev_grant && grant == '0) check_ev(EV_REL);
        end
        prev_grant = grant;
        prev_slave = slave_en;
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // One arbitration round from request to visible release, driven cycle by cycle.
    task automatic run_txn(input logic [NM-1:0] mask, input int addr, input int kind,
                           input int off);
        int c, w, c0, d, r;
        logic [NM-1:0] rv, sv, dv;
        c  = cyc;
        w  = rr_winner(mask);
        c0 = c + 2 + int'(SL);
        if (kind == K_DONE)      d = c0 + off;
        else if (kind == K_DROP) d = c + 1 + off;
        else                     d = c0 + int'(TMO) - 1;
        r = d + 2;
        push_ev(EV_GRANT, c + 1, w, addr, 1'b0);
        if (!(kind == K_DROP && d < c0)) push_ev(EV_SLAVE, c0, w, addr, 1'b1);
        if (kind == K_TMO) push_ev(EV_TMO, c0 + int'(TMO), w, addr, 1'b1);
        push_ev(EV_REL, r, w, addr, 1'b0);
        for (int t = c; t < r; t++) begin
            wait_cyc(t);
            rv = mask;
            if (kind == K_DROP && t >= d) rv[w] = 1'b0;
            sv = NM'($urandom);
            if (t >= c + 2 && t < c0) sv[w] = 1'((addr >> (t - c - 2)) & 1);
            dv = ($urandom_range(0, 3) == 0) ? NM'($urandom) : '0;
            dv = dv & ~oh_m(w);
            if (kind == K_DONE && t == d) dv[w] = 1'b1;
            req    = rv;
            sel_in = sv;
            done   = dv;
        end
        wait_cyc(r);
        model_last = w;
    endtask

    initial begin
        int c, w, kind, off;
        logic [NM-1:0] m;

        repeat (2) @(negedge clk);
        req = '1;
        @(negedge clk);
        chk("reset_grant", int'(grant), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_owner", int'(owner), 0);
        chk("reset_slave_en", int'(slave_en), 0);
        chk("reset_timeout", int'(timeout), 0);
        req   = '0;
        reset = 1'b0;
        @(negedge clk);

        run_txn(2'b11, 1, K_DONE, 2);
        run_txn(2'b11, 2, K_DONE, 0);
        run_txn(2'b01, 0, K_TMO, 0);
        run_txn(2'b01, 3, K_TMO, 0);
        run_txn(2'b01, 2, K_DROP, 2);
        run_txn(2'b10, 1, K_DONE, int'(TMO) - 1);
        run_txn(2'b11, 3, K_DROP, 0);

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) begin
                req  = '0;
                done = '0;
                @(negedge clk);
            end
            m    = NM'($urandom_range(1, (1 << NM) - 1));
            kind = int'($urandom_range(0, 2));
            off  = (kind == K_DONE) ? int'($urandom_range(0, TMO - 1))
                                    : int'($urandom_range(0, SL + 5));
            run_txn(m, int'($urandom_range(0, SLAVE_W - 1)), kind, off);
        end

        // Reset while connected to slave 3.
        c = cyc;
        w = rr_winner(2'b01);
        push_ev(EV_GRANT, c + 1, w, 3, 1'b0);
        push_ev(EV_SLAVE, c + 2 + int'(SL), w, 3, 1'b1);
        for (int t = c; t < c + 2 + int'(SL) + 3; t++) begin
            wait_cyc(t);
            req    = 2'b01;
            sel_in = NM'($urandom);
            if (t >= c + 2 && t < c + 2 + int'(SL)) sel_in[w] = 1'b1;
            done   = '0;
        end
        wait_cyc(c + 2 + int'(SL) + 3);
        chk("connected_slave_en", int'(slave_en), 8);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("async_reset_grant", int'(grant), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_owner", int'(owner), 0);
        chk("async_reset_slave_en", int'(slave_en), 0);
        chk("async_reset_timeout", int'(timeout), 0);
        @(negedge clk);
        @(negedge clk);
        req        = '0;
        reset      = 1'b0;
        model_last = int'(NM) - 1;
        @(negedge clk);
        run_txn(2'b10, 2, K_DONE, 1);
        run_txn(2'b11, 0, K_DONE, 3);

        req  = '0;
        done = '0;
        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached with %0d events pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the serial system bus between NUM_MASTERS master ports and routes the granted master to one slave.
- Accepts approval requests and issues a one-hot grant, with round-robin fairness.
- Reports busy to losing masters.
- Captures the granted master's serial slave-select bits, then drives a one-hot slave enable.
- Holds the connection until the master signals done, drops its request, or a timeout expires.

Parameters:
- NUM_MASTERS, 2, number of requesting master ports.
- SLAVE_LEN, 2, serial slave-select bits per transaction; 2**SLAVE_LEN slaves.
- TIMEOUT, 4096, maximum CONNECTED cycles before forced release.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- req  in  NUM_MASTERS  approval_request from each master.
- sel_in  in  NUM_MASTERS  serial tx_slave_select from each master.
- done  in  NUM_MASTERS  tx_done/rx_done pulse from each master.
- grant  out  NUM_MASTERS  one-hot approval_grant.
- busy  out  NUM_MASTERS  per-master busy: bus owned by another master.
- owner  out  $clog2(NUM_MASTERS)  index of granted master, for the data-path mux.
- slave_en  out  2**SLAVE_LEN  one-hot slave enable.
- timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Interface decision: reset reset, asynchronous, active-high; clock clk. All outputs are registered.
- Reset values: grant=0, busy=0, owner=0, slave_en=0, timeout=0, state=IDLE, last=NUM_MASTERS-1 (master 0 wins first), counters=0.
- Reset mid-transaction returns to IDLE immediately and drops grant and slave_en.
- States: IDLE, GRANT, ADDR, CONNECTED, RELEASE.
- IDLE:
  - If req!=0, winner w = first set req bit scanning from last+1 upward with wrap.
  - Next edge: grant[w]=1, owner=w, state=GRANT. Latency from req to grant is 1 cycle.
  - busy[i]=1 for every i!=w from the same edge until RELEASE.
- GRANT: lasts exactly one cycle while the master loads its first select bit; bit counter=0, then ADDR.
- ADDR:
  - Samples sel_in[w] on SLAVE_LEN consecutive edges, LSB first, into a shift register.
  - After the last bit, the next edge sets slave_en = one-hot(captured value) and state=CONNECTED.
- CONNECTED:
  - Cycle counter increments each cycle.
  - Exit to RELEASE on done[w]=1, or req[w]=0, or counter==TIMEOUT-1; the timeout case also pulses timeout.
  - If done and timeout coincide, done has priority and no timeout pulse is issued.
- req[w] dropping during GRANT or ADDR aborts to RELEASE without asserting slave_en.
- RELEASE:
  - One cycle: grant, busy and slave_en go to 0; last=w; state=IDLE.
  - A new grant is possible on the following cycle, giving 1 dead cycle between owners.
- Requests from other masters are ignored, not queued, while the bus is owned. They are evaluated in IDLE only.
- done and sel_in from non-owners are ignored.
- A held req after release is re-arbitrated normally, so it wins only if no other master has priority.
- The counter saturates and does not wrap; it is cleared on every RELEASE.

Decomposition:
- Shared package bus_pkg:
  - State enum.
  - Width constants OWNER_W=$clog2(NUM_MASTERS) and SLAVE_W=2**SLAVE_LEN.
  - Shared with the master and slave ports.
- Sub-module rr_picker: combinational round-robin winner selection from req and last, with output valid plus index.

Test Plan:
- Single request, master 0, sel_in bits 1,0 (slave 1): grant[0] 1 cycle after req, slave_en=4'b0010 after GRANT plus 2 ADDR cycles; done[0] pulse → RELEASE then all zero.
- Simultaneous req=2'b11 after reset: master 0 granted and busy[1]=1. After release with both still requesting, master 1 is granted next, confirming the round-robin alternation.
- Master holds without done, TIMEOUT=16: timeout pulses once at CONNECTED cycle 16, grant drops next cycle, and the counter restarts at 0 on the next grant.
- req[0] dropped during ADDR: slave_en never asserted, RELEASE, then IDLE.
- Reset asserted in CONNECTED with slave_en=4'b1000: all outputs 0 asynchronously; after reset, a new req=2'b10 grants master 1 first.
- done and timeout on the same cycle: release occurs with timeout=0.
